sign_abs_to_bipolar: RTL
========================

# sign_abs_to_bipolar

Converts a sign-magnitude unary pair (sign bit stream plus unipolar magnitude bitstream) back into a single bipolar bitstream, so it is the inverse of the bipolar-to-sign/abs stage in the unary kernel library. It sits after unipolar-only kernels (e.g. unipolar multipliers or sqrt) that operate on a magnitude, and restores a signed bipolar stream for downstream bipolar kernels. A saturating sign-filter counter suppresses sign flicker, and a balanced filler toggle encodes magnitude-0 cycles as neutral bipolar bits.

## Interface
- DEP, 3: sign-filter counter width (≥2).
- FILT, 1: 1 = use the filtered sign; 0 = use raw `sign_in` directly, and the counter is still maintained.

- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- en  input  1  stream advance enable; 0 freezes all state
- sign_in  input  1  per-cycle sign bit (1 = negative)
- mag  input  1  unipolar magnitude bitstream
- out  output  1  bipolar bitstream (registered)
- sign_q  output  1  sign applied to the most recent `out` bit (registered)

## Operation
- Sign filter: counter `cnt[DEP-1:0]`, reset value 1<<(DEP-1).
  - If `en` is high and `sign_in`=1 and cnt≠0: decrement.
  - If `en` is high and `sign_in`=0 and cnt≠all-ones: increment.
  - Otherwise cnt holds. Saturating at both ends; no wrap-around.
- `sign_f = ~cnt[DEP-1]`, combinational from the current (pre-update) cnt.
- `sign_use = FILT ? sign_f : sign_in`.
- Filler toggle `tgl`, reset 0. `tgl` flips only on cycles where `en`=1 and `mag`=0.
- Output bit, computed when `en`=1:
  - `mag`=1: bit = ~sign_use.
  - `mag`=0: bit = `tgl` (pre-flip value).
- Resulting probability: P(out=1) = (1 + (1−2s)·m)/2, an exact bipolar encoding of ±m.
- When `en`=0, cnt, tgl, `out` and `sign_q` all hold.
- All arithmetic is unsigned DEP-bit. Saturation checks use the all-ones and all-zeros reductions of cnt.

## Timing
- Latency: 1 cycle. `out`/`sign_q` at edge t+1 reflect `mag`/`sign_in`/cnt/tgl sampled at edge t.
- Reset values: `out`=0, `sign_q`=0, cnt=1<<(DEP-1), tgl=0.
- Reset is asynchronous. Asserting `rst_n` mid-stream forces the reset values immediately, regardless of `en` or `clk`. The first post-reset edge behaves exactly as after power-up.
- Sign changes in FILT=1 mode:
  - From midpoint, a continuous `sign_in`=1 flips `sign_f` to 1 after 1 edge.
  - From the positive rail (all-ones), it takes 2^(DEP−1) edges.
- Simultaneous events on one edge:
  - Counter update, tgl flip and output register all occur together.
  - The output uses the pre-update cnt and tgl.
- There is no handshake beyond `en`. Producer and consumer streams must be cycle-aligned.

## Structure
- Shared unary-kernel package holds the sign-polarity constants SIGN_POS=1'b0 and SIGN_NEG=1'b1, and a `cnt_mid(DEP)` constant function returning 1<<(DEP-1).
- One sub-module, `sign_filter`:
  - Parameter DEP.
  - Ports: clk, rst_n, en, sign_in, sign_f.
  - Contains the saturating counter only.
- The top-level holds tgl, the output mux and the output registers.

## Test plan
1. Reset, then `en`=1, `mag`=1, `sign_in`=0, FILT=1, DEP=3 → during reset out=0, sign_q=0; after release out=1 every cycle; cnt saturates at 7 after 3 edges and stays 7.
2. `mag`=0 for 8 cycles after reset → out sequence 0,1,0,1,0,1,0,1, independent of `sign_in`.
3. From reset, `mag`=1, `sign_in`=1 held → out=1 on the first edge (cnt 4→3), then out=0 and sign_q=1 on every following edge; cnt bottoms at 0 after 4 edges, and 12 further edges leave cnt=0.
4. Saturate at cnt=7, then apply `sign_in`=1 with `mag`=1 → out stays 1 for 4 edges (cnt 7→3) and is 0 from the 5th edge; with FILT=0 the same stimulus gives out=0 from the 1st edge.
5. Mid-stream `en`=0 for 5 cycles with random `mag`/`sign_in` → out, sign_q, cnt and tgl are unchanged; resuming `en`=1 continues the sequence exactly where it stopped.
6. Asynchronous reset pulse asserted between clock edges mid-stream (cnt=0, tgl=1) → out=0, sign_q=0, cnt=4, tgl=0 immediately; 1000-cycle random stream with m=0.5, s=1 → out ones-density 0.25 ±0.03.

Source files
------------

// File: rtl/sign_abs_to_bipolar_pkg.sv
// Shared unary-kernel definitions: sign polarity constants and the
// sign-filter counter midpoint helper.
package sign_abs_to_bipolar_pkg;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  // Reset/midpoint value of a DEP-bit sign-filter counter.
  function automatic int unsigned cnt_mid(input int unsigned dep);
    return 32'd1 << (dep - 32'd1);
  endfunction

endpackage

// File: rtl/sign_abs_to_bipolar_if.sv
// Stream-side signals of the sign/abs to bipolar converter; enable is the
// only flow control, so producer and consumer must stay cycle-aligned.
interface sign_abs_to_bipolar_if;
  logic en;
  logic sign_in;
  logic mag;
  logic out;
  logic sign_q;

  modport master (output en, output sign_in, output mag,
                  input  out, input  sign_q);
  modport slave  (input  en, input  sign_in, input  mag,
                  output out, output sign_q);
endinterface

// File: rtl/sign_abs_to_bipolar_sign_filter.sv
// Saturating up/down counter that debounces the per-cycle sign bit; the
// filtered sign is negative whenever the counter sits below its midpoint.
module sign_filter
  import sign_abs_to_bipolar_pkg::*;
#(
  parameter int DEP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sign_in,
  output logic sign_f
);

  localparam logic [DEP-1:0] CNT_RST = DEP'(cnt_mid(DEP));
  localparam logic [DEP-1:0] CNT_ONE = DEP'(1);

  logic [DEP-1:0] cnt_q;
  logic [DEP-1:0] cnt_d;

  // Next count: step toward the sampled sign, clamped at both rails.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (sign_in == SIGN_NEG) begin
        if (|cnt_q) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sign_f = ~cnt_q[DEP-1];

endmodule

// File: rtl/sign_abs_to_bipolar.sv
// Recombines a sign stream and a unipolar magnitude stream into one bipolar
// stream; magnitude-0 cycles emit an alternating filler bit (bipolar zero).
module sign_abs_to_bipolar
  import sign_abs_to_bipolar_pkg::*;
#(
  parameter int DEP  = 3,
  parameter int FILT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sign_abs_to_bipolar_if.slave  bus
);

  logic sign_f;
  logic sign_use;
  logic tgl_q, tgl_d;
  logic out_q, out_d;
  logic sgn_q, sgn_d;

  sign_filter #(.DEP(DEP)) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.en),
    .sign_in (bus.sign_in),
    .sign_f  (sign_f)
  );

  assign sign_use = (FILT != 0) ? sign_f : bus.sign_in;

  // Output mux and filler toggle; both see the pre-update counter and toggle.
  always_comb begin
    tgl_d = tgl_q;
    out_d = out_q;
    sgn_d = sgn_q;
    if (bus.en) begin
      sgn_d = sign_use;
      if (bus.mag) begin
        out_d = ~sign_use;
        tgl_d = tgl_q;
      end else begin
        out_d = tgl_q;
        tgl_d = ~tgl_q;
      end
    end else begin
      tgl_d = tgl_q;
    end
  end

  // Output and toggle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_q <= 1'b0;
      out_q <= 1'b0;
      sgn_q <= SIGN_POS;
    end else begin
      tgl_q <= tgl_d;
      out_q <= out_d;
      sgn_q <= sgn_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.sign_q = sgn_q;

endmodule
